// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU-priority two-port arbiter for the shared data memory with streak limit and locked ext bursts
module dmem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int CPU_STREAK = 4,
  parameter int EXT_BURST  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_lock,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);
  localparam int SW = $clog2(CPU_STREAK + 1);
  localparam int BW = $clog2(EXT_BURST + 1);
  localparam logic [SW-1:0] SMAX = SW'(CPU_STREAK);
  localparam logic [BW-1:0] BMAX = BW'(EXT_BURST);
  typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_CPU = 2'b01, OWN_EXT = 2'b10} owner_e;
  owner_e owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [BW-1:0] burst_q, burst_d;
  logic lock_hold;
  always_comb begin
    lock_hold = owner_q == OWN_EXT && ext_req && ext_lock && (burst_q < BMAX || !cpu_req);
    ext_gnt   = !reset && (lock_hold || (ext_req && (!cpu_req || streak_q == SMAX)));
    cpu_gnt   = !reset && !lock_hold && cpu_req && !(ext_req && streak_q == SMAX);
    cpu_stall = cpu_req && !cpu_gnt;
    owner_d   = cpu_gnt ? OWN_CPU : ext_gnt ? OWN_EXT : OWN_NONE;
    streak_d  = (cpu_gnt && ext_req) ? (streak_q == SMAX ? SMAX : streak_q + 1'b1) : '0;
    burst_d   = !ext_gnt ? '0 : owner_q != OWN_EXT ? BW'(1) : burst_q == BMAX ? BMAX : burst_q + 1'b1;
    mem_addr  = cpu_gnt ? cpu_addr : ext_gnt ? ext_addr : '0;
    mem_wdata = cpu_gnt ? cpu_wdata : ext_gnt ? ext_wdata : '0;
    mem_we    = (cpu_gnt && cpu_we) || (ext_gnt && ext_we);
    cpu_rdata = cpu_gnt ? mem_rdata : '0;
    ext_rdata = ext_gnt ? mem_rdata : '0;
    owner     = owner_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      streak_q <= '0;
      burst_q  <= '0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
      burst_q  <= burst_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench driving directed arbitration vectors against a 256x8 memory model
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, ext_req = 1'b0, ext_lock = 1'b0, ext_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0, ext_addr = '0, ext_wdata = '0;
  logic cpu_gnt, cpu_stall, ext_gnt, mem_we;
  logic [7:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0] owner;
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [21:0] exp_q [$];
  string name_q [$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_lock(ext_lock), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .owner(owner)
  );
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  function automatic logic [21:0] ex(input logic cg, eg, we, st, input logic [1:0] own, input logic [7:0] crd, erd);
    return {cg, eg, we, st, own, crd, erd};
  endfunction
  task automatic cyc(input string nm, input logic rs, cr, cw, input logic [7:0] ca, cd,
                     input logic er, el, ew, input logic [7:0] ea, ed, input logic [21:0] x);
    reset = rs;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_lock = el; ext_we = ew; ext_addr = ea; ext_wdata = ed;
    exp_q.push_back(x);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [21:0] e, a;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      a = {cpu_gnt, ext_gnt, mem_we, cpu_stall, owner, cpu_rdata, ext_rdata};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got cg=%b eg=%b we=%b st=%b own=%b crd=%h erd=%h, want cg=%b eg=%b we=%b st=%b own=%b crd=%h erd=%h",
                 nm, a[21], a[20], a[19], a[18], a[17:16], a[15:8], a[7:0],
                 e[21], e[20], e[19], e[18], e[17:16], e[15:8], e[7:0]);
      end
    end
  end
  initial begin
    @(posedge clk);
    #1;
    cyc("rst_idle", 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, ex(0, 0, 0, 0, 2'd0, 8'h00, 8'h00));
    cyc("rst_cpu", 1, 1, 1, 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00, ex(0, 0, 0, 1, 2'd0, 8'h00, 8'h00));
    cyc("cpu_wr", 0, 1, 1, 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00, ex(1, 0, 1, 0, 2'd0, 8'h00, 8'h00));
    cyc("cpu_rd", 0, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, ex(1, 0, 0, 0, 2'd1, 8'hA5, 8'h00));
    cyc("idle1", 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, ex(0, 0, 0, 0, 2'd1, 8'h00, 8'h00));
    for (int i = 0; i < 10; i++) begin
      logic e;
      logic [1:0] own;
      e = (i % 5 == 4);
      own = (i == 0) ? 2'd0 : (i % 5 == 0) ? 2'd2 : 2'd1;
      cyc("streak", 0, 1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h10, 8'h00,
          ex(!e, e, 0, e, own, e ? 8'h00 : 8'hA5, e ? 8'hA5 : 8'h00));
    end
    for (int i = 0; i < 4; i++)
      cyc("wr_wait", 0, 1, 0, 8'h80, 8'h00, 1, 0, 1, 8'h80, 8'h3C, ex(1, 0, 0, 0, i == 0 ? 2'd2 : 2'd1, 8'h00, 8'h00));
    cyc("ext_wr80", 0, 1, 0, 8'h80, 8'h00, 1, 0, 1, 8'h80, 8'h3C, ex(0, 1, 1, 1, 2'd1, 8'h00, 8'h00));
    cyc("cpu_rd80", 0, 1, 0, 8'h80, 8'h00, 0, 0, 0, 8'h00, 8'h00, ex(1, 0, 0, 0, 2'd2, 8'h3C, 8'h00));
    cyc("idle2", 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, ex(0, 0, 0, 0, 2'd1, 8'h00, 8'h00));
    for (int i = 0; i < 2; i++)
      cyc("lock_solo", 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h80, 8'h00, ex(0, 1, 0, 0, i == 0 ? 2'd0 : 2'd2, 8'h00, 8'h3C));
    for (int i = 0; i < 6; i++)
      cyc("lock_cpu", 0, 1, 0, 8'h10, 8'h00, 1, 1, 0, 8'h80, 8'h00, ex(0, 1, 0, 1, 2'd2, 8'h00, 8'h3C));
    cyc("lock_end", 0, 1, 0, 8'h10, 8'h00, 1, 1, 0, 8'h80, 8'h00, ex(1, 0, 0, 0, 2'd2, 8'hA5, 8'h00));
    for (int i = 0; i < 11; i++)
      cyc("lock_sat", 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h80, 8'h00, ex(0, 1, 0, 0, i == 0 ? 2'd1 : 2'd2, 8'h00, 8'h3C));
    cyc("lock_cpu_in", 0, 1, 0, 8'h10, 8'h00, 1, 1, 0, 8'h80, 8'h00, ex(1, 0, 0, 0, 2'd2, 8'hA5, 8'h00));
    cyc("ext_wr20", 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h20, 8'h77, ex(0, 1, 1, 0, 2'd1, 8'h00, 8'h00));
    cyc("rst_ext_wr", 1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h10, 8'h55, ex(0, 0, 0, 0, 2'd2, 8'h00, 8'h00));
    cyc("rst_cpu2", 1, 1, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00, ex(0, 0, 0, 1, 2'd0, 8'h00, 8'h00));
    cyc("post_ext_rd", 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h10, 8'h00, ex(0, 1, 0, 0, 2'd0, 8'h00, 8'hA5));
    cyc("post_cpu_rd", 0, 1, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00, ex(1, 0, 0, 0, 2'd2, 8'h77, 8'h00));
    for (int i = 0; i < 5; i++)
      cyc("post_streak", 0, 1, 0, 8'h20, 8'h00, 1, 0, 0, 8'h10, 8'h00,
          i == 4 ? ex(0, 1, 0, 1, 2'd1, 8'h00, 8'hA5) : ex(1, 0, 0, 0, i == 0 ? 2'd1 : 2'd1, 8'h77, 8'h00));
    cyc("idle3", 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, ex(0, 0, 0, 0, 2'd2, 8'h00, 8'h00));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single 256x8 data memory between the CPU core and an external requester (loader/debug/DMA port). It muxes address, write data and write enable into the memory, returns read data to the granted port, and raises a stall toward the core when the core's access is deferred. The block sits between the core's data-memory address and data path and the `data_memory` instance. Arbitration is CPU-priority, with a starvation counter and a bounded locked burst for the external port.

## Interface
Parameters:
- ADDR_W, 8, address width
- DATA_W, 8, data width
- CPU_STREAK, 4, maximum consecutive CPU grants while ext_req is pending (≥1)
- EXT_BURST, 8, maximum consecutive locked ext grants while cpu_req is pending (≥1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_rdata  out  DATA_W  read data; 0 when not granted
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes PC and registers in the core
- ext_req  in  1  external access request
- ext_lock  in  1  request to keep ownership for the next access (burst)
- ext_we, ext_addr, ext_wdata  in  1/ADDR_W/DATA_W  as for the CPU
- ext_gnt  out  1  ext access performed this cycle
- ext_rdata  out  DATA_W  read data; 0 when not granted
- mem_addr  out  ADDR_W  to data_memory address
- mem_wdata  out  DATA_W  to data_memory data_in
- mem_we  out  1  to data_memory write_enable
- mem_rdata  in  DATA_W  from data_memory data_out (combinational read)
- owner  out  2  registered last owner: 00 NONE, 01 CPU, 10 EXT

## Operation
- State: owner (NONE/CPU/EXT), streak_cnt (0..CPU_STREAK), burst_cnt (0..EXT_BURST). Reset values: NONE, 0, 0.
- Grant decision, combinational, at most one grant per cycle, evaluated in this priority order:
  1. owner==EXT & ext_req & ext_lock & (burst_cnt<EXT_BURST | ~cpu_req) → EXT
  2. cpu_req & ext_req → EXT if streak_cnt==CPU_STREAK, else CPU
  3. cpu_req only → CPU; ext_req only → EXT; neither → none
- Update on a CPU grant:
  - owner←CPU
  - streak_cnt←ext_req ? min(streak_cnt+1, CPU_STREAK) : 0
  - burst_cnt←0
- Update on an EXT grant:
  - owner←EXT
  - streak_cnt←0
  - burst_cnt←(owner==EXT) ? min(burst_cnt+1, EXT_BURST) : 1
- Update on no grant: owner←NONE, both counters←0.
- Memory mux:
  - Granted port's addr/wdata drive mem_addr/mem_wdata; mem_we = granted port's we.
  - With no grant: mem_addr=0, mem_wdata=0, mem_we=0.
- x_rdata = mem_rdata while x_gnt=1, else 0.
- ext_lock is ignored unless owner==EXT; a lock never pre-empts the CPU once the CPU has taken ownership.

## Timing
- Grant latency is 0 cycles: gnt is combinational from req and registered state.
- A write commits at the rising edge ending the granted cycle. Read data is valid in the same granted cycle.
- Requesters hold req/we/addr/wdata stable until they sample gnt=1 at an edge. The access is complete at that edge; dropping req afterwards is legal.
- cpu_stall is combinational and matches ~cpu_gnt whenever cpu_req=1.
- While reset=1: all gnt=0, mem_we=0, cpu_stall=cpu_req. State clears at the edge, so a write in progress is dropped, never partial.
- The worst-case CPU wait with ext_lock held is EXT_BURST cycles. The worst-case ext wait is CPU_STREAK cycles.
- Counters saturate and never wrap.
- If either requester drops req mid-sequence, its counter state resets as specified above; there is no hidden pending state.

## Test plan
- Reset, then cpu_req=1 only, write addr 0x10 data 0xA5, then read 0x10 → cpu_gnt=1 both cycles, mem_we=1 then 0, cpu_rdata=0xA5, owner=01, cpu_stall=0.
- cpu_req and ext_req held continuously, ext_lock=0, defaults → grant pattern CPU,CPU,CPU,CPU,EXT repeating; cpu_stall=1 exactly on each EXT cycle.
- ext_req alone with ext_lock=1 for 2 cycles, then cpu_req also asserted → 8 consecutive EXT grants in total (burst_cnt reaches 8), then CPU granted; cpu_stall=1 for 6 cycles.
- Locked ext burst with cpu_req=0 → EXT granted indefinitely, burst_cnt saturates at 8; raising cpu_req then gives CPU the next cycle.
- ext write 0x3C→0x80 in the same cycle cpu_req reads 0x80 with streak_cnt=4 → ext_gnt, mem_we=1, cpu_stall=1; next cycle CPU granted and cpu_rdata=0x3C.
- Assert reset during a cycle where EXT is granted with we=1 → no grants or mem_we while reset is high, memory unchanged; after release owner=00 and the counters restart at 0.
